axis_rr_arbiter: RTL

Round-robin, packet-locking arbiter that shares one AXI-Stream-style FIFO write port between NUM_REQ upstream requesters. It sits directly in front of the team's stream FIFO. Its master port drives the FIFO's s_data/s_valid, and the FIFO's s_ready returns on m_ready. A grant holds until the granted requester completes a packet (last beat) or MAX_BURST beats have transferred, whichever comes first. The arbiter then rotates priority.

---
 rtl/axis_rr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Round-robin, packet-locking arbiter that lets NUM_REQ AXI-Stream-style
// requesters share one FIFO write port. A grant is held until the granted
// requester sends its last beat or MAX_BURST beats have gone through. Priority
// then rotates to the requester after the one that was just served. Between two
// grants there is always one idle cycle.
//
// Ports
//   i_aclk     : clock, all logic on the rising edge
//   i_areset   : synchronous active-high reset; also gates o_m_valid/o_s_ready
//   i_s_data   : requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_s_valid  : per-requester valid
//   i_s_last   : per-requester end-of-packet marker
//   o_s_ready  : per-requester ready (only the granted one can be high)
//   o_m_data   : data to FIFO (combinational mux of the granted requester)
//   o_m_valid  : valid to FIFO
//   o_m_last   : last marker to FIFO
//   i_m_ready  : FIFO ready (not full)
//   o_grant    : registered one-hot grant, all zero when idle
//   o_busy     : registered, high while a grant is locked
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          i_aclk,
  input  logic                          i_areset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_s_data,
  input  logic [NUM_REQ-1:0]            i_s_valid,
  input  logic [NUM_REQ-1:0]            i_s_last,
  output logic [NUM_REQ-1:0]            o_s_ready,
  output logic [DATA_WIDTH-1:0]         o_m_data,
  output logic                          o_m_valid,
  output logic                          o_m_last,
  input  logic                          i_m_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [PW-1:0]        r_gidx;      // binary index of the granted requester
  logic [PW-1:0]        r_rr_ptr;    // last requester served
  logic [CW-1:0]        r_beat_cnt;
  logic                 r_busy;

  logic [DATA_WIDTH-1:0] w_s_data [NUM_REQ];
  logic                  w_sel_found;
  logic [PW-1:0]         w_sel_idx;
  logic [NUM_REQ-1:0]    w_sel_onehot;
  logic                  w_xfer;
  logic                  w_release;

  // Unpack the flat requester data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_s_data[gi] = i_s_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Find the first valid requester strictly after r_rr_ptr, with wrap.
  // The loop walks offsets from largest to smallest so that the nearest
  // candidate is the last one written and therefore wins. The modulo is done
  // with an explicit subtract so non-power-of-two NUM_REQ wraps correctly.
  always_comb begin
    int cand;
    cand        = 0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(r_rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (i_s_valid[cand[PW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = cand[PW-1:0];
      end
    end
  end

  assign w_sel_onehot = NUM_REQ'(1) << w_sel_idx;

  // Combinational data path: no pipeline register between requester and FIFO.
  // Reset gates the handshake so nothing moves in a reset cycle.
  assign o_m_data  = w_s_data[r_gidx];
  assign o_m_valid = r_busy & i_s_valid[r_gidx] & ~i_areset;
  assign o_m_last  = r_busy & i_s_last[r_gidx];
  assign o_s_ready = (r_busy && i_m_ready && !i_areset) ? r_grant : '0;

  assign w_xfer    = o_m_valid & i_m_ready;
  // A forced release at MAX_BURST leaves m_last untouched; the packet simply
  // continues under a later grant.
  assign w_release = i_s_last[r_gidx] || (r_beat_cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= PW'(NUM_REQ - 1);   // requester 0 gets first priority
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_found) begin
            r_state    <= ST_LOCK;
            r_grant    <= w_sel_onehot;
            r_gidx     <= w_sel_idx;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_LOCK: begin
          // Without a transfer everything holds; an idle source never loses
          // its grant.
          if (w_xfer) begin
            if (w_release) begin
              r_state    <= ST_IDLE;
              r_rr_ptr   <= r_gidx;
              r_beat_cnt <= '0;
              r_grant    <= '0;
              r_busy     <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = r_busy;

endmodule
